// File: rtl/mod_count_display_pkg.sv
// Shared constants for the count display: active-low segment patterns {g,f,e,d,c,b,a},
// active-low anode patterns and the digit-scan state type.
package mod_count_display_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  localparam logic [3:0] AN_D0  = 4'b1110;
  localparam logic [3:0] AN_D1  = 4'b1101;
  localparam logic [3:0] AN_D2  = 4'b1011;
  localparam logic [3:0] AN_D3  = 4'b0111;
  localparam logic [3:0] AN_OFF = 4'b1111;

  // Decoder code reserved for "show a dash"; any of 10..15 would do.
  localparam logic [3:0] CODE_DASH = 4'hA;

  typedef enum logic [1:0] {
    StDig0,
    StDig1,
    StDig2,
    StDig3
  } digit_e;

endpackage

// File: rtl/mod_count_display_if.sv
// Counter-side inputs and board-side display outputs of mod_count_display.
interface mod_count_display_if;
  logic [2:0] count_in;
  logic       mod_toggle_in;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;
  logic [7:0] tally;
  logic       tally_ovf;

  modport master (
    output count_in, mod_toggle_in,
    input  seg, an, dp, tally, tally_ovf
  );

  modport slave (
    input  count_in, mod_toggle_in,
    output seg, an, dp, tally, tally_ovf
  );
endinterface

// File: rtl/mod_count_display_seg7_decoder.sv
// Combinational 4-bit code to active-low seven-segment pattern; codes 10..15 show a dash.
module mod_count_display_seg7_decoder
  import mod_count_display_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (code)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/mod_count_display.sv
// Live count, blank, and BCD wrap tally on a 4-digit multiplexed seven-segment display.
// Optional BLANK_LEADING_ZERO_EN blanks the tens digit while it is zero.
module mod_count_display
  import mod_count_display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned COUNT_MOD   = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  mod_count_display_if.slave   bus
);

  localparam int unsigned RefW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  logic [RefW-1:0] refresh_q, refresh_d;
  logic            refresh_tc;
  digit_e          idx_q, idx_d;

  logic            prev_q;
  logic            wrap;
  logic [3:0]      ones_q, ones_d, tens_q, tens_d;
  logic            ovf_q, ovf_d;
  logic [RefW-1:0] act_q, act_d;

  logic [2:0]      count_q;
  logic [3:0]      code;
  logic            blank;
  logic [6:0]      dec_seg;
  logic [6:0]      seg_q, seg_d;
  logic [3:0]      an_q, an_d;
  logic            dp_q, dp_d;

  assign refresh_tc = (refresh_q == RefW'(REFRESH_DIV - 1));
  assign refresh_d  = refresh_tc ? '0 : refresh_q + RefW'(1);

  // The counter's T-FF toggles once per wrap, so either edge of it is a wrap.
  assign wrap = bus.mod_toggle_in ^ prev_q;

  always_comb begin
    idx_d = idx_q;
    if (refresh_tc) begin
      unique case (idx_q)
        StDig0: idx_d = StDig1;
        StDig1: idx_d = StDig2;
        StDig2: idx_d = StDig3;
        StDig3: idx_d = StDig0;
      endcase
    end
  end

  always_comb begin
    ones_d = ones_q;
    tens_d = tens_q;
    ovf_d  = 1'b0;
    if (wrap) begin
      if (ones_q == 4'd9) begin
        ones_d = 4'd0;
        if (tens_q == 4'd9) begin
          tens_d = 4'd0;
          ovf_d  = 1'b1;
        end else begin
          tens_d = tens_q + 4'd1;
        end
      end else begin
        ones_d = ones_q + 4'd1;
      end
    end
  end

  // Activity window: nonzero for REFRESH_DIV-1 cycles after the most recent wrap.
  always_comb begin
    act_d = act_q;
    if (wrap) begin
      act_d = RefW'(REFRESH_DIV - 1);
    end else if (act_q != '0) begin
      act_d = act_q - RefW'(1);
    end
  end

  always_comb begin
    code  = 4'd0;
    blank = 1'b0;
    an_d  = AN_OFF;
    unique case (idx_q)
      StDig0: begin
        an_d = AN_D0;
        code = (32'(count_q) >= COUNT_MOD) ? CODE_DASH : {1'b0, count_q};
      end
      StDig1: begin
        an_d  = AN_D1;
        blank = 1'b1;
      end
      StDig2: begin
        an_d = AN_D2;
        code = ones_q;
      end
      StDig3: begin
        an_d = AN_D3;
        code = tens_q;
`ifdef BLANK_LEADING_ZERO_EN
        blank = (tens_q == 4'd0);
`else
        blank = 1'b0;
`endif
      end
    endcase
  end

  mod_count_display_seg7_decoder u_decoder (
    .code (code),
    .seg  (dec_seg)
  );

  assign seg_d = blank ? SEG_BLANK : dec_seg;
  assign dp_d  = !((idx_q == StDig1) && (act_q != '0));

  always_ff @(posedge clk) begin
    if (reset) begin
      refresh_q <= '0;
      idx_q     <= StDig0;
      prev_q    <= bus.mod_toggle_in;
      ones_q    <= 4'd0;
      tens_q    <= 4'd0;
      ovf_q     <= 1'b0;
      act_q     <= '0;
      seg_q     <= SEG_BLANK;
      an_q      <= AN_OFF;
      dp_q      <= 1'b1;
    end else begin
      refresh_q <= refresh_d;
      idx_q     <= idx_d;
      prev_q    <= bus.mod_toggle_in;
      ones_q    <= ones_d;
      tens_q    <= tens_d;
      ovf_q     <= ovf_d;
      act_q     <= act_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
      dp_q      <= dp_d;
    end
  end

  // Input stage for the live count; its value is don't-care until it reaches the pins.
  always_ff @(posedge clk) begin
    count_q <= bus.count_in;
  end

  assign bus.seg       = seg_q;
  assign bus.an        = an_q;
  assign bus.dp        = dp_q;
  assign bus.tally     = {tens_q, ones_q};
  assign bus.tally_ovf = ovf_q;

endmodule

// File: tb/tb_mod_count_display.sv
// Self-checking bench for mod_count_display: cycle model plus directed table and sequences.
module tb_mod_count_display;

  localparam int REF = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mod_count_display_if bus ();

  mod_count_display #(
    .REFRESH_DIV (REF),
    .COUNT_MOD   (6)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  // Reference model state
  int         m_n;
  int         m_tally;
  int         m_cnt_reg;
  int         m_last;
  logic       m_prev;
  int         m_idx;
  logic [6:0] e_seg;
  logic [3:0] e_an;
  logic       e_dp;
  logic       e_ovf;
  logic [6:0] last_seg[4];
  int         ovf_cnt;

  typedef struct {
    int         n_tog;
    logic [2:0] cnt;
    logic [7:0] exp_tally;
    logic [6:0] exp_d0;
    logic [6:0] exp_d2;
    logic [6:0] exp_d3;
  } vec_t;

  vec_t vecs[4];

  function automatic logic [6:0] seg_of(int d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // One clock: model the edge from the inputs in force, then compare all outputs.
  task automatic step();
    logic was_reset;
    @(posedge clk);
    was_reset = reset;
    if (reset) begin
      e_seg = 7'h7F; e_an = 4'hF; e_dp = 1'b1; e_ovf = 1'b0;
      m_tally = 0; m_n = 0; m_last = -1; m_idx = -1;
    end else begin
      m_n++;
      m_idx = ((m_n - 1) / REF) % 4;
      e_an  = ~(4'(1) << m_idx);
      case (m_idx)
        0: e_seg = (m_cnt_reg >= 6) ? 7'h3F : seg_of(m_cnt_reg);
        1: e_seg = 7'h7F;
        2: e_seg = seg_of(m_tally % 10);
        default: begin
`ifdef BLANK_LEADING_ZERO_EN
          e_seg = (m_tally / 10 == 0) ? 7'h7F : seg_of(m_tally / 10);
`else
          e_seg = seg_of(m_tally / 10);
`endif
        end
      endcase
      e_dp  = !(m_idx == 1 && m_last >= 0 && (m_n - m_last) < REF);
      e_ovf = 1'b0;
      if (bus.mod_toggle_in != m_prev) begin
        e_ovf   = (m_tally == 99);
        m_tally = (m_tally + 1) % 100;
        m_last  = m_n;
      end
    end
    m_prev    = bus.mod_toggle_in;
    m_cnt_reg = int'(bus.count_in);
    #1;
    check("seg", 32'(bus.seg), 32'(e_seg));
    check("an", 32'(bus.an), 32'(e_an));
    check("dp", 32'(bus.dp), 32'(e_dp));
    check("tally", 32'(bus.tally), 32'((m_tally / 10) * 16 + (m_tally % 10)));
    check("tally_ovf", 32'(bus.tally_ovf), 32'(e_ovf));
    if (!was_reset) last_seg[m_idx] = bus.seg;
    if (bus.tally_ovf === 1'b1) ovf_cnt++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{n_tog: 12, cnt: 3'd3, exp_tally: 8'h12, exp_d0: 7'h30, exp_d2: 7'h24,
                exp_d3: 7'h79};
    vecs[1] = '{n_tog: 0, cnt: 3'd6, exp_tally: 8'h12, exp_d0: 7'h3F, exp_d2: 7'h24,
                exp_d3: 7'h79};
    vecs[2] = '{n_tog: 0, cnt: 3'd7, exp_tally: 8'h12, exp_d0: 7'h3F, exp_d2: 7'h24,
                exp_d3: 7'h79};
`ifdef BLANK_LEADING_ZERO_EN
    vecs[3] = '{n_tog: 93, cnt: 3'd5, exp_tally: 8'h05, exp_d0: 7'h12, exp_d2: 7'h12,
                exp_d3: 7'h7F};
`else
    vecs[3] = '{n_tog: 93, cnt: 3'd5, exp_tally: 8'h05, exp_d0: 7'h12, exp_d2: 7'h12,
                exp_d3: 7'h40};
`endif
    for (int i = 0; i < 4; i++) last_seg[i] = 7'h00;

    // Reset held with the toggle high: no false wrap on release.
    reset = 1'b1;
    bus.count_in = 3'd0;
    bus.mod_toggle_in = 1'b1;
    ovf_cnt = 0;
    repeat (3) step();
    reset = 1'b0;
    step();
    check("t1_first_an", 32'(bus.an), 32'(4'b1110));
    repeat (7) step();
    check("t1_tally", 32'(bus.tally), 32'h00);
    check("t1_no_ovf", 32'(ovf_cnt), 32'd0);

    // Live count 3 over a full scan.
    bus.count_in = 3'd3;
    repeat (16) step();
    check("t2_seg_d0", 32'(last_seg[0]), 32'(7'h30));

    // Directed vectors: toggles spaced 5 cycles, then a full scan to refresh every digit.
    for (int v = 0; v < 4; v++) begin
      bus.count_in = vecs[v].cnt;
      for (int k = 0; k < vecs[v].n_tog; k++) begin
        bus.mod_toggle_in = ~bus.mod_toggle_in;
        repeat (5) step();
      end
      repeat (20) step();
      check($sformatf("vec%0d_tally", v), 32'(bus.tally), 32'(vecs[v].exp_tally));
      check($sformatf("vec%0d_d0", v), 32'(last_seg[0]), 32'(vecs[v].exp_d0));
      check($sformatf("vec%0d_d2", v), 32'(last_seg[2]), 32'(vecs[v].exp_d2));
      check($sformatf("vec%0d_d3", v), 32'(last_seg[3]), 32'(vecs[v].exp_d3));
    end

    // 99 -> 00 rollover with a single-cycle overflow pulse.
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int k = 0; k < 99; k++) begin
      bus.mod_toggle_in = ~bus.mod_toggle_in;
      repeat (2) step();
    end
    check("t4_tally99", 32'(bus.tally), 32'h99);
    ovf_cnt = 0;
    bus.mod_toggle_in = ~bus.mod_toggle_in;
    step();
    check("t4_ovf_now", 32'(bus.tally_ovf), 32'd1);
    repeat (9) step();
    check("t4_ovf_once", 32'(ovf_cnt), 32'd1);
    check("t4_tally00", 32'(bus.tally), 32'h00);

    // Reset coinciding with a toggle while digit 2 is being selected.
    bus.mod_toggle_in = ~bus.mod_toggle_in;
    step();
    for (int k = 0; k < 20 && ((m_n / REF) % 4) != 2; k++) step();
    check("t6_at_idx2", 32'((m_n / REF) % 4), 32'd2);
    reset = 1'b1;
    bus.mod_toggle_in = ~bus.mod_toggle_in;
    step();
    check("t6_tally", 32'(bus.tally), 32'h00);
    check("t6_an_off", 32'(bus.an), 32'hF);
    reset = 1'b0;
    step();
    check("t6_restart_idx0", 32'(bus.an), 32'(4'b1110));

    // Randomized traffic against the model.
    for (int c = 0; c < 600; c++) begin
      bus.count_in = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) bus.mod_toggle_in = ~bus.mod_toggle_in;
      reset = ($urandom_range(0, 99) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
